sme_param: RTL and testbench

Parametrised string-matching engine, the next generation of the fixed 32-char/8-char matcher in the contest design set. It loads a string and then one or more patterns over a shared byte bus and searches the stored string for each pattern. The metacharacters `^`, `$`, `.` and any number of `*` are supported, and a per-pattern case-insensitive mode is added. Each result is reported with a one-cycle `valid` pulse, together with the match flag and the leftmost match start index.

---
 rtl/sme_param.sv | 222 ++++++++++++++++++++++
 tb/tb_sme_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sme_param.sv
// Parametrised string matcher: loads a string and patterns over a byte bus, then
// searches with ^ $ . * and optional case folding, reporting the leftmost match start.
module sme_param #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDXW    = $clog2(STR_MAX)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      chardata,
    input  logic            isstring,
    input  logic            ispattern,
    input  logic            nocase,
    output logic            valid,
    output logic            match,
    output logic [IDXW-1:0] match_index
);
    localparam int CW  = IDXW + 1;
    localparam int PW  = $clog2(PAT_MAX + 1);
    localparam int PIW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         str_q [STR_MAX];
    logic [7:0]         str_d [STR_MAX];
    logic [7:0]         pat_q [PAT_MAX];
    logic [7:0]         pat_d [PAT_MAX];
    logic [CW-1:0]      slen_q, slen_d, s_q, s_d, p_q, p_d;
    logic [PW-1:0]      plen_q, plen_d;
    logic               nocase_q, nocase_d, init_q, init_d;
    logic [PAT_MAX:0]   nfa_q, nfa_d;
    logic               valid_q, valid_d, match_q, match_d;
    logic [IDXW-1:0]    idx_q, idx_d;

    logic               anc_s_s, anc_e_s, accept_s, prev_ok_s, fin_s, found_s;
    logic [PW-1:0]      b0_s, b1_s;
    logic [PAT_MAX-1:0] body_s, star_s, hit_s;
    logic [PAT_MAX:0]   start_s, step_s, next_nfa_s;
    logic [7:0]         cur_s;
    logic [CW-1:0]      sm1_s;

    function automatic logic [7:0] fold(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    endfunction

    function automatic logic char_eq(input logic [7:0] a, input logic [7:0] b, input logic nc);
        return nc ? (fold(a) == fold(b)) : (a == b);
    endfunction

    // A star position also lets the NFA advance past it without consuming a byte.
    function automatic logic [PAT_MAX:0] closure(input logic [PAT_MAX:0] v,
                                                 input logic [PAT_MAX-1:0] star);
        logic [PAT_MAX:0] r;
        r = v;
        for (int j = 0; j < PAT_MAX; j++) begin
            r[j+1] = r[j+1] | (r[j] & star[j]);
        end
        return r;
    endfunction

    // Pattern anchors, per-position hits and the NFA step for the current byte.
    always_comb begin
        anc_s_s = (pat_q[0] == 8'h5E);
        anc_e_s = 1'b0;
        for (int j = 0; j < PAT_MAX; j++) begin
            anc_e_s = anc_e_s | ((PW'(j + 1) == plen_q) && (pat_q[j] == 8'h24));
        end
        b0_s   = anc_s_s ? PW'(1) : PW'(0);
        b1_s   = plen_q - (anc_e_s ? PW'(1) : PW'(0));
        cur_s  = str_q[p_q[IDXW-1:0]];
        sm1_s  = s_q - CW'(1);
        step_s = {(PAT_MAX+1){1'b0}};
        for (int j = 0; j < PAT_MAX; j++) begin
            body_s[j]   = (PW'(j) >= b0_s) && (PW'(j) < b1_s);
            star_s[j]   = body_s[j] && (pat_q[j] == 8'h2A);
            hit_s[j]    = body_s[j] && !star_s[j] &&
                          ((pat_q[j] == 8'h2E) || char_eq(pat_q[j], cur_s, nocase_q));
            step_s[j+1] = step_s[j+1] | (nfa_q[j] & hit_s[j]);
            step_s[j]   = step_s[j] | (nfa_q[j] & star_s[j]);
        end
        start_s    = closure({{PAT_MAX{1'b0}}, 1'b1} << b0_s, star_s);
        next_nfa_s = closure(step_s, star_s);
        accept_s   = nfa_q[b1_s] && (!anc_e_s || (p_q == slen_q) || (cur_s == 8'h20));
        prev_ok_s  = (s_q == {CW{1'b0}}) || (str_q[sm1_s[IDXW-1:0]] == 8'h20);
    end

    // Search termination: every start tried, or the current start accepted.
    always_comb begin
        fin_s   = 1'b0;
        found_s = 1'b0;
        if (init_q) begin
            fin_s = (s_q > slen_q);
        end else begin
            fin_s   = accept_s;
            found_s = accept_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = isstring ? LOAD_STR : (ispattern ? LOAD_PAT : IDLE);
            LOAD_STR:   state_d = isstring ? LOAD_STR : (ispattern ? LOAD_PAT : IDLE);
            LOAD_PAT:   state_d = ispattern ? LOAD_PAT : SEARCH;
            SEARCH:     state_d = fin_s ? DONE : SEARCH;
            default:    state_d = IDLE;
        endcase
    end

    // Storage loading, the per-start search walk and the result registers.
    always_comb begin
        str_d    = str_q;
        pat_d    = pat_q;
        slen_d   = slen_q;
        plen_d   = plen_q;
        nocase_d = nocase_q;
        s_d      = s_q;
        p_d      = p_q;
        init_d   = init_q;
        nfa_d    = nfa_q;
        valid_d  = 1'b0;
        match_d  = match_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE, DONE, LOAD_STR: begin
                if (isstring) begin
                    if (state_q != LOAD_STR) begin
                        str_d[0] = chardata;
                        slen_d   = CW'(1);
                    end else if (slen_q < CW'(STR_MAX)) begin
                        str_d[slen_q[IDXW-1:0]] = chardata;
                        slen_d = slen_q + CW'(1);
                    end else begin
                        slen_d = slen_q;
                    end
                end else if (ispattern) begin
                    pat_d[0] = chardata;
                    plen_d   = PW'(1);
                    nocase_d = nocase;
                end else begin
                    plen_d = plen_q;
                end
            end
            LOAD_PAT: begin
                if (ispattern) begin
                    if (plen_q < PW'(PAT_MAX)) begin
                        pat_d[plen_q[PIW-1:0]] = chardata;
                        plen_d = plen_q + PW'(1);
                    end else begin
                        plen_d = plen_q;
                    end
                end else begin
                    s_d    = {CW{1'b0}};
                    init_d = 1'b1;
                end
            end
            SEARCH: begin
                if (fin_s) begin
                    valid_d = 1'b1;
                    match_d = found_s;
                    idx_d   = found_s ? s_q[IDXW-1:0] : {IDXW{1'b0}};
                end else if (init_q) begin
                    if (anc_s_s && !prev_ok_s) begin
                        s_d = s_q + CW'(1);
                    end else begin
                        nfa_d  = start_s;
                        p_d    = s_q;
                        init_d = 1'b0;
                    end
                end else if ((p_q == slen_q) || (nfa_q == {(PAT_MAX+1){1'b0}})) begin
                    s_d    = s_q + CW'(1);
                    init_d = 1'b1;
                end else begin
                    nfa_d = next_nfa_s;
                    p_d   = p_q + CW'(1);
                end
            end
            default: begin
                init_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            for (int i = 0; i < STR_MAX; i++) str_q[i] <= 8'h00;
            for (int i = 0; i < PAT_MAX; i++) pat_q[i] <= 8'h00;
            slen_q   <= {CW{1'b0}};
            plen_q   <= {PW{1'b0}};
            nocase_q <= 1'b0;
            s_q      <= {CW{1'b0}};
            p_q      <= {CW{1'b0}};
            init_q   <= 1'b0;
            nfa_q    <= {(PAT_MAX+1){1'b0}};
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
            idx_q    <= {IDXW{1'b0}};
        end else begin
            state_q  <= state_d;
            str_q    <= str_d;
            pat_q    <= pat_d;
            slen_q   <= slen_d;
            plen_q   <= plen_d;
            nocase_q <= nocase_d;
            s_q      <= s_d;
            p_q      <= p_d;
            init_q   <= init_d;
            nfa_q    <= nfa_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            idx_q    <= idx_d;
        end
    end

    assign valid       = valid_q;
    assign match       = match_q;
    assign match_index = idx_q;
endmodule

// File: tb/tb_sme_param.sv
// Bench for sme_param: directed patterns with literal expectations, a dynamic-programming
// glob model, and a per-cycle checker for result values and output hold.
module tb_sme_param;
    localparam int BOUND = (32 + 1) * (32 + 8 + 1) + 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] chardata;
    logic       isstring, ispattern, nocase;
    logic       valid, match;
    logic [4:0] match_index;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mstr [0:63];
    int         mlen;
    logic [7:0] mpat [0:7];
    int         mplen;
    bit         exp_m [0:63];
    int         exp_i [0:63];
    int         wr_ptr;
    int         rd_ptr;
    bit         last_m;
    int         last_i;

    sme_param dut (
        .clk(clk), .reset(rst_n), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .nocase(nocase), .valid(valid), .match(match),
        .match_index(match_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] lc(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
    endfunction

    // Leftmost start s for which some end e makes the pattern body cover str[s..e).
    task automatic model_search(input bit nc, output bit m, output int idx);
        bit dp [0:8][0:32];
        bit as_, ae;
        int b0, b1;
        m = 0; idx = 0;
        as_ = (mplen > 0) && (mpat[0] == 8'h5E);
        ae  = (mplen > 0) && (mpat[mplen-1] == 8'h24);
        b0  = as_ ? 1 : 0;
        b1  = ae ? mplen - 1 : mplen;
        for (int s = 0; s <= mlen && !m; s++) begin
            if (!as_ || s == 0 || mstr[s-1] == 8'h20) begin
                for (int j = 0; j <= 8; j++) for (int i = 0; i <= 32; i++) dp[j][i] = 0;
                dp[b0][s] = 1;
                for (int j = b0; j < b1; j++) begin
                    for (int i = s; i <= mlen; i++) begin
                        if (dp[j][i]) begin
                            if (mpat[j] == 8'h2A) begin
                                for (int k = i; k <= mlen; k++) dp[j+1][k] = 1;
                            end else if (i < mlen && (mpat[j] == 8'h2E || mpat[j] == mstr[i] ||
                                         (nc && lc(mpat[j]) == lc(mstr[i])))) begin
                                dp[j+1][i+1] = 1;
                            end
                        end
                    end
                end
                for (int e = s; e <= mlen; e++) begin
                    if (!m && dp[b1][e] && (!ae || e == mlen || mstr[e] == 8'h20)) begin
                        m = 1; idx = s;
                    end
                end
            end
        end
    endtask

    task automatic send_str(input string t);
        mlen = 0;
        for (int i = 0; i < t.len(); i++) begin
            if (mlen < 32) begin mstr[mlen] = t[i]; mlen++; end
            isstring = 1'b1; chardata = t[i];
            @(negedge clk);
        end
        isstring = 1'b0;
    endtask

    task automatic drive_pat(input string p, input bit nc);
        for (int i = 0; i < p.len(); i++) begin
            ispattern = 1'b1; chardata = p[i];
            nocase = (i == 0) ? nc : !nc;
            @(negedge clk);
        end
        ispattern = 1'b0; nocase = 1'b0;
    endtask

    task automatic run_pat(input string nm, input string p, input bit nc, input bit em, input int ei);
        bit mm; int mi; int cnt; bit seen;
        mplen = 0;
        for (int i = 0; i < p.len(); i++) if (mplen < 8) begin mpat[mplen] = p[i]; mplen++; end
        model_search(nc, mm, mi);
        chk({nm, "_model_m"}, mm, em);
        chk({nm, "_model_i"}, mi, ei);
        exp_m[wr_ptr] = mm; exp_i[wr_ptr] = mi; wr_ptr++;
        drive_pat(p, nc);
        cnt = 0; seen = 0;
        while (!seen && cnt < BOUND + 40) begin
            @(negedge clk);
            cnt++;
            seen = valid;
        end
        chk({nm, "_valid_seen"}, seen, 1);
        if (seen) begin
            chk({nm, "_lat_min"}, (cnt - 1) >= 2, 1);
            chk({nm, "_lat_max"}, (cnt - 1) <= BOUND, 1);
            chk({nm, "_match"}, match, em);
            chk({nm, "_index"}, match_index, ei);
        end
    endtask

    // Per-cycle checker: model result on valid, otherwise outputs must hold.
    initial begin
        rd_ptr = 0; last_m = 0; last_i = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_valid", valid, 0);
                chk("rst_match", match, 0);
                chk("rst_index", match_index, 0);
                rd_ptr = wr_ptr; last_m = 0; last_i = 0;
            end else if (valid) begin
                if (rd_ptr == wr_ptr) begin
                    chk("unexpected_valid", valid, 0);
                end else begin
                    chk("model_match", match, exp_m[rd_ptr]);
                    chk("model_index", match_index, exp_i[rd_ptr]);
                    rd_ptr++;
                end
                last_m = match; last_i = match_index;
            end else begin
                chk("hold_match", match, last_m);
                chk("hold_index", match_index, last_i);
            end
        end
    end

    initial begin
        string s40;
        rst_n = 1'b0; isstring = 1'b0; ispattern = 1'b0; nocase = 1'b0; chardata = 8'h00;
        wr_ptr = 0; mlen = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);

        send_str("the cat sat");
        run_pat("cat",   "cat",   1'b0, 1'b1, 4);
        run_pat("dog",   "dog",   1'b0, 1'b0, 0);
        run_pat("a_sat", "^sat",  1'b0, 1'b1, 8);
        run_pat("a_at",  "^at",   1'b0, 1'b0, 0);
        run_pat("at_e",  "at$",   1'b0, 1'b1, 5);
        run_pat("cst",   "c*t",   1'b0, 1'b1, 4);
        run_pat("ssat",  "*sat",  1'b0, 1'b1, 0);
        run_pat("ssz",   "s*z",   1'b0, 1'b0, 0);
        run_pat("tat",   "t*a*t", 1'b0, 1'b1, 0);
        run_pat("cdt",   "c.t",   1'b0, 1'b1, 4);
        run_pat("CAT1",  "CAT",   1'b1, 1'b1, 4);
        run_pat("CAT0",  "CAT",   1'b0, 1'b0, 0);
        run_pat("cat0",  "cat",   1'b0, 1'b1, 4);
        run_pat("ovf_pat", "e cat saQQ", 1'b0, 1'b1, 2);

        s40 = "";
        for (int i = 0; i < 40; i++) begin
            if (i == 35)      s40 = {s40, "x"};
            else if (i == 36) s40 = {s40, "y"};
            else if (i == 37) s40 = {s40, "z"};
            else              s40 = {s40, "a"};
        end
        send_str(s40);
        run_pat("ovf_str", "xyz", 1'b0, 1'b0, 0);

        send_str("the cat sat");
        run_pat("pre_done", "cat", 1'b0, 1'b1, 4);
        send_str("xx sat");
        run_pat("done_str", "sat", 1'b0, 1'b1, 3);

        drive_pat("s*z", 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        mlen = 0;
        repeat (40) begin
            @(negedge clk);
            chk("abort_no_valid", valid, 0);
        end
        chk("abort_match", match, 0);
        chk("abort_index", match_index, 0);

        run_pat("e_star", "*",  1'b0, 1'b1, 0);
        run_pat("e_anch", "^$", 1'b0, 1'b1, 0);
        run_pat("e_dol",  "$",  1'b0, 1'b1, 0);
        run_pat("e_lit",  "a",  1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
